mcpu: RTL and testbench
=======================

MCPU -- requirements
Module: mcpu

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): OPCODE_SIZE, 4, opcode field width.
REQ-002 OPERAND_SIZE, 4, register-index field width; WORD_SIZE, 8, register/data width; INSTR_SIZE, 16, instruction and memory word width.
REQ-003 RAM_SIZE, 256, memory words (in submodule raminst); REGISTERS_NUMBER, 16, general registers (in submodule regfileinst).
REQ-004 Opcode parameters SHALL be: OP_SHORT_TO_REG=0, OP_STORE_TO_MEM=1, OP_LOAD_FROM_MEM=2, OP_ADD=3, OP_XOR=4, OP_AND=5, OP_OR=6, OP_MOV=7, OP_BNZ=8; codes 9-15 are NOP.
REQ-005 Ports: clk  input  1  single clock, all state updates on rising edge.
REQ-006 Ports: reset  input  1  synchronous, active-high reset.
REQ-007 Hierarchy SHALL be: instance raminst holding array mem[0:RAM_SIZE-1] of INSTR_SIZE bits; instance regfileinst holding array R[0:REGISTERS_NUMBER-1] of WORD_SIZE bits; 8-bit register pc at top level. Benches preload and inspect these by hierarchical path.

Function
REQ-008 Instruction format SHALL be [15:12] opcode, [11:8] rd, [7:0] imm8/addr8; for register ops [7:4] rs1, [3:0] rs2.
REQ-009 Memory SHALL be unified (code and data), combinational read, synchronous write; address is 8 bits, no wrap logic needed.
REQ-010 Control SHALL be a 3-state FSM FETCH -> DECODE -> EXECUTE -> FETCH, one state per clock, exactly 3 cycles per instruction for every opcode.
REQ-011 FETCH: IR <= mem[pc]. DECODE: latch A <= R[IR[7:4]], B <= R[IR[3:0]], D <= R[IR[11:8]].
REQ-012 EXECUTE SHALL perform: SHORT_TO_REG R[rd]=imm8; STORE_TO_MEM mem[addr8]={8'b0,R[rd]}; LOAD_FROM_MEM R[rd]=mem[addr8][7:0].
REQ-013 EXECUTE SHALL perform: ADD R[rd]=(A+B) mod 256, carry discarded; XOR A^B; AND A&B; OR A|B; MOV R[rd]=A (rs2 ignored).
REQ-014 BNZ SHALL set pc=imm8 when R[rd]!=0, else pc=pc+1; NOP changes only pc (pc+1).
REQ-015 pc SHALL change only in EXECUTE; all non-branch instructions set pc=pc+1 modulo 256 (255 wraps to 0).
REQ-016 All 16 registers SHALL be general purpose (R0 writable/readable, not hard-wired).
REQ-017 Register writes occur at the EXECUTE edge; the next instruction's DECODE SHALL observe the written value (no hazards, no forwarding needed).
REQ-018 Source and destination may coincide (e.g. ADD R1,R1,R1); result uses values latched in DECODE.

Reset
REQ-019 While reset is high at a rising edge: pc=0, state=FETCH, IR=0, A/B/D=0.
REQ-020 Reset SHALL NOT clear memory or register file contents (preloaded program/data survive).
REQ-021 Reset asserted mid-instruction SHALL abort it with no register/memory write on that edge; execution restarts at address 0.

Verification
REQ-022 Preload mem[0]=SHORT_TO_REG R14,26; mem[1]=STORE R14,100; run 6 cycles after reset -> R[14]=26, mem[100]=26, pc=2.
REQ-023 R12=26, R13=41 via LOAD from 100/101 -> ADD R10,R12,R13 gives 67; XOR R11 gives 51.
REQ-024 R6=99, R7=11 -> AND R4 gives 3; OR R5 gives 107; MOV R2,R4 gives 3; MOV R3,R5 gives 107.
REQ-025 Full 19-instruction program (above sequence ending BNZ R2,0 at address 18) -> after 57 cycles post-reset pc=0, all above register/memory values hold and loop repeats identically.
REQ-026 BNZ with R[rd]=0 -> pc=pc+1; ADD 200+100 -> 44 (wrap).
REQ-027 Assert reset during EXECUTE of a STORE -> target memory word unchanged, pc=0, state FETCH next cycle.

Source files
------------

// File: rtl/mcpu_if.sv
// mcpu_if -- debug/status bundle exported by the mcpu core.
// The core drives this bundle through the master modport. Observers use the slave modport.
//   state : current control state (0 = FETCH, 1 = DECODE, 2 = EXECUTE)
//   pc    : program counter
//   ir    : instruction register
interface mcpu_if #(
  parameter int INSTR_SIZE = 16
);
  logic [1:0]            state;
  logic [7:0]            pc;
  logic [INSTR_SIZE-1:0] ir;

  modport master (output state, output pc, output ir);
  modport slave  (input  state, input  pc, input  ir);
endinterface

// File: rtl/mcpu.sv
// mcpu -- small multi-cycle CPU. Each instruction passes through FETCH, DECODE and
// EXECUTE, so every instruction takes exactly 3 clocks. Code and data share one memory.
//   clk    : single clock; all state changes on the rising edge
//   reset  : synchronous, active-high. Clears pc, FSM, IR, A, B and D.
//            Memory and the register file keep their contents.
//   dbg    : mcpu_if.master; exports state, pc and ir
// Submodules:
//   raminst     : mem[0:RAM_SIZE-1] words of INSTR_SIZE bits; combinational read, synchronous write
//   regfileinst : R[0:REGISTERS_NUMBER-1] words of WORD_SIZE bits; all registers are general purpose

module mcpu_ram #(
  parameter int INSTR_SIZE = 16,
  parameter int RAM_SIZE   = 256
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [7:0]            waddr_i,
  input  logic [INSTR_SIZE-1:0] wdata_i,
  input  logic [7:0]            raddr0_i,
  output logic [INSTR_SIZE-1:0] rdata0_o,
  input  logic [7:0]            raddr1_i,
  output logic [INSTR_SIZE-1:0] rdata1_o
);
  logic [INSTR_SIZE-1:0] mem [0:RAM_SIZE-1];

  assign rdata0_o = mem[raddr0_i];
  assign rdata1_o = mem[raddr1_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
endmodule

module mcpu_regfile #(
  parameter int WORD_SIZE        = 8,
  parameter int OPERAND_SIZE     = 4,
  parameter int REGISTERS_NUMBER = 16
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [OPERAND_SIZE-1:0] waddr_i,
  input  logic [WORD_SIZE-1:0]    wdata_i,
  input  logic [OPERAND_SIZE-1:0] raddr_a_i,
  output logic [WORD_SIZE-1:0]    rdata_a_o,
  input  logic [OPERAND_SIZE-1:0] raddr_b_i,
  output logic [WORD_SIZE-1:0]    rdata_b_o,
  input  logic [OPERAND_SIZE-1:0] raddr_d_i,
  output logic [WORD_SIZE-1:0]    rdata_d_o
);
  logic [WORD_SIZE-1:0] R [0:REGISTERS_NUMBER-1];

  assign rdata_a_o = R[raddr_a_i];
  assign rdata_b_o = R[raddr_b_i];
  assign rdata_d_o = R[raddr_d_i];

  always_ff @(posedge clk_i) begin
    if (we_i) R[waddr_i] <= wdata_i;
  end
endmodule

module mcpu #(
  parameter int OPCODE_SIZE      = 4,
  parameter int OPERAND_SIZE     = 4,
  parameter int WORD_SIZE        = 8,
  parameter int INSTR_SIZE       = 16,
  parameter int RAM_SIZE         = 256,
  parameter int REGISTERS_NUMBER = 16
) (
  input  logic   clk,
  input  logic   reset,
  mcpu_if.master dbg
);
  localparam logic [OPCODE_SIZE-1:0] OP_SHORT_TO_REG  = 0;
  localparam logic [OPCODE_SIZE-1:0] OP_STORE_TO_MEM  = 1;
  localparam logic [OPCODE_SIZE-1:0] OP_LOAD_FROM_MEM = 2;
  localparam logic [OPCODE_SIZE-1:0] OP_ADD           = 3;
  localparam logic [OPCODE_SIZE-1:0] OP_XOR           = 4;
  localparam logic [OPCODE_SIZE-1:0] OP_AND           = 5;
  localparam logic [OPCODE_SIZE-1:0] OP_OR            = 6;
  localparam logic [OPCODE_SIZE-1:0] OP_MOV           = 7;
  localparam logic [OPCODE_SIZE-1:0] OP_BNZ           = 8;

  typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_DECODE = 2'd1, ST_EXECUTE = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [INSTR_SIZE-1:0] ir_q, ir_d;
  logic [WORD_SIZE-1:0]  a_q, a_d, b_q, b_d, d_q, d_d;
  logic [7:0]            pc, pc_d;

  // Instruction fields (register ops reuse the low byte as rs1/rs2)
  logic [OPCODE_SIZE-1:0]  op;
  logic [OPERAND_SIZE-1:0] rd, rs1, rs2;
  logic [7:0]              imm8;
  assign op   = ir_q[15:12];
  assign rd   = ir_q[11:8];
  assign rs1  = ir_q[7:4];
  assign rs2  = ir_q[3:0];
  assign imm8 = ir_q[7:0];

  logic [INSTR_SIZE-1:0] fetch_word, load_word, mem_wdata;
  logic                  mem_we, reg_we;
  logic [WORD_SIZE-1:0]  reg_wdata, rf_a, rf_b, rf_d;

  mcpu_ram #(.INSTR_SIZE(INSTR_SIZE), .RAM_SIZE(RAM_SIZE)) raminst (
    .clk_i    (clk),
    .we_i     (mem_we),
    .waddr_i  (imm8),
    .wdata_i  (mem_wdata),
    .raddr0_i (pc),
    .rdata0_o (fetch_word),
    .raddr1_i (imm8),
    .rdata1_o (load_word)
  );

  mcpu_regfile #(
    .WORD_SIZE(WORD_SIZE), .OPERAND_SIZE(OPERAND_SIZE), .REGISTERS_NUMBER(REGISTERS_NUMBER)
  ) regfileinst (
    .clk_i     (clk),
    .we_i      (reg_we),
    .waddr_i   (rd),
    .wdata_i   (reg_wdata),
    .raddr_a_i (rs1),
    .rdata_a_o (rf_a),
    .raddr_b_i (rs2),
    .rdata_b_o (rf_b),
    .raddr_d_i (rd),
    .rdata_d_o (rf_d)
  );

  // Loads only take the low byte of the memory word.
  logic unused_load_bits;
  assign unused_load_bits = &{1'b0, load_word[INSTR_SIZE-1:WORD_SIZE]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc      <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    reg_we    = 1'b0;
    reg_wdata = '0;
    mem_we    = 1'b0;
    mem_wdata = {{(INSTR_SIZE-WORD_SIZE){1'b0}}, d_q};

    case (state_q)
      ST_FETCH: begin
        ir_d    = fetch_word;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        d_d     = rf_d;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        pc_d    = pc + 8'd1;
        case (op)
          OP_SHORT_TO_REG:  begin reg_we = 1'b1; reg_wdata = imm8; end
          OP_STORE_TO_MEM:  mem_we = 1'b1;
          OP_LOAD_FROM_MEM: begin reg_we = 1'b1; reg_wdata = load_word[WORD_SIZE-1:0]; end
          OP_ADD:           begin reg_we = 1'b1; reg_wdata = a_q + b_q; end
          OP_XOR:           begin reg_we = 1'b1; reg_wdata = a_q ^ b_q; end
          OP_AND:           begin reg_we = 1'b1; reg_wdata = a_q & b_q; end
          OP_OR:            begin reg_we = 1'b1; reg_wdata = a_q | b_q; end
          OP_MOV:           begin reg_we = 1'b1; reg_wdata = a_q; end
          OP_BNZ:           if (d_q != '0) pc_d = imm8;
          default:          ;
        endcase
      end
      default: state_d = ST_FETCH;
    endcase

    // A reset edge aborts the instruction in flight; no write may land on that edge.
    if (reset) begin
      reg_we = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign dbg.state = state_q;
  assign dbg.pc    = pc;
  assign dbg.ir    = ir_q;
endmodule

// File: tb/tb_mcpu.sv
// tb_mcpu -- directed programs plus a random instruction stream for mcpu.
// The random stream is compared against an instruction-level interpreter of the ISA.
// Preloads and inspections go through dut.raminst.mem, dut.regfileinst.R and dut.pc.
module tb_mcpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mcpu_if #(.INSTR_SIZE(16)) dbg_if ();

  mcpu dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg_if)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state only.
  logic [15:0] m_mem [0:255];
  logic [7:0]  m_r   [0:15];
  logic [7:0]  m_pc;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_mem(input int addr, input logic [15:0] val);
    dut.raminst.mem[addr] <= val;
    m_mem[addr] = val;
  endtask

  task automatic put_reg(input int idx, input logic [7:0] val);
    dut.regfileinst.R[idx] <= val;
    m_r[idx] = val;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) put_mem(i, 16'h0000);
  endtask

  // One whole instruction at ISA level.
  task automatic model_step();
    logic [15:0] ir;
    logic [7:0]  a, b, nxt;
    int          rd;
    ir  = m_mem[m_pc];
    rd  = int'(ir[11:8]);
    a   = m_r[ir[7:4]];
    b   = m_r[ir[3:0]];
    nxt = m_pc + 8'd1;
    case (ir[15:12])
      4'd0: m_r[rd] = ir[7:0];
      4'd1: m_mem[ir[7:0]] = {8'h00, m_r[rd]};
      4'd2: m_r[rd] = m_mem[ir[7:0]][7:0];
      4'd3: m_r[rd] = 8'((int'(a) + int'(b)) % 256);
      4'd4: m_r[rd] = a ^ b;
      4'd5: m_r[rd] = a & b;
      4'd6: m_r[rd] = a | b;
      4'd7: m_r[rd] = a;
      4'd8: if (m_r[rd] != 8'd0) nxt = ir[7:0];
      default: ;
    endcase
    m_pc = nxt;
  endtask

  initial begin
    // ---------------- Program from the reference sequence ----------------
    @(negedge clk);
    clear_mem();
    put_mem(0,  16'h0E1A); // SHORT R14,26
    put_mem(1,  16'h1E64); // STORE R14,100
    put_mem(2,  16'h0D29); // SHORT R13,41
    put_mem(3,  16'h1D65); // STORE R13,101
    put_mem(4,  16'h2C64); // LOAD  R12,100
    put_mem(5,  16'h2D65); // LOAD  R13,101
    put_mem(6,  16'h3ACD); // ADD   R10,R12,R13
    put_mem(7,  16'h4BCD); // XOR   R11,R12,R13
    put_mem(8,  16'h0663); // SHORT R6,99
    put_mem(9,  16'h070B); // SHORT R7,11
    put_mem(10, 16'h5467); // AND   R4,R6,R7
    put_mem(11, 16'h6567); // OR    R5,R6,R7
    put_mem(12, 16'h7240); // MOV   R2,R4
    put_mem(13, 16'h7350); // MOV   R3,R5
    put_mem(14, 16'h9000); // NOP
    put_mem(15, 16'hF000); // NOP
    put_mem(16, 16'hA000); // NOP
    put_mem(17, 16'h0001); // SHORT R0,1
    put_mem(18, 16'h8200); // BNZ   R2,0
    do_reset();
    check("reset_state", 32'(dbg_if.state), 32'd0);
    check("reset_pc", 32'(dbg_if.pc), 32'd0);
    check("reset_ir", 32'(dbg_if.ir), 32'd0);
    check("reset_abd", {8'h00, dut.a_q, dut.b_q, dut.d_q}, 32'd0);

    tick(6);
    check("p6_r14", 32'(dut.regfileinst.R[14]), 32'd26);
    check("p6_mem100", 32'(dut.raminst.mem[100]), 32'd26);
    check("p6_pc", 32'(dbg_if.pc), 32'd2);

    tick(51);
    check("p57_pc", 32'(dbg_if.pc), 32'd0);
    check("p57_state", 32'(dbg_if.state), 32'd0);
    check("p57_mem101", 32'(dut.raminst.mem[101]), 32'd41);
    check("p57_r12", 32'(dut.regfileinst.R[12]), 32'd26);
    check("p57_r13", 32'(dut.regfileinst.R[13]), 32'd41);
    check("p57_r10_add", 32'(dut.regfileinst.R[10]), 32'd67);
    check("p57_r11_xor", 32'(dut.regfileinst.R[11]), 32'd51);
    check("p57_r4_and", 32'(dut.regfileinst.R[4]), 32'd3);
    check("p57_r5_or", 32'(dut.regfileinst.R[5]), 32'd107);
    check("p57_r2_mov", 32'(dut.regfileinst.R[2]), 32'd3);
    check("p57_r3_mov", 32'(dut.regfileinst.R[3]), 32'd107);
    check("p57_r0_gp", 32'(dut.regfileinst.R[0]), 32'd1);

    tick(57);
    check("loop2_pc", 32'(dbg_if.pc), 32'd0);
    check("loop2_r10", 32'(dut.regfileinst.R[10]), 32'd67);
    check("loop2_r5", 32'(dut.regfileinst.R[5]), 32'd107);
    check("loop2_mem100", 32'(dut.raminst.mem[100]), 32'd26);

    // ---------------- Branch-not-taken, add wrap, pc wrap ----------------
    clear_mem();
    put_mem(0,   16'h0100); // SHORT R1,0
    put_mem(1,   16'h8132); // BNZ   R1,50 (not taken)
    put_mem(2,   16'h08C8); // SHORT R8,200
    put_mem(3,   16'h0964); // SHORT R9,100
    put_mem(4,   16'h3889); // ADD   R8,R8,R9
    put_mem(5,   16'h88FF); // BNZ   R8,255 (taken)
    put_mem(255, 16'h9000); // NOP at the top of memory
    do_reset();
    tick(3);
    check("bnz_pre_pc", 32'(dbg_if.pc), 32'd1);
    tick(3);
    check("bnz_zero_pc", 32'(dbg_if.pc), 32'd2);
    tick(9);
    check("add_wrap_r8", 32'(dut.regfileinst.R[8]), 32'd44);
    check("add_wrap_pc", 32'(dbg_if.pc), 32'd5);
    tick(3);
    check("bnz_taken_pc", 32'(dbg_if.pc), 32'd255);
    tick(3);
    check("pc_wrap", 32'(dbg_if.pc), 32'd0);

    // ---------------- Reset during EXECUTE of a STORE ----------------
    clear_mem();
    put_mem(0,   16'h014D); // SHORT R1,77
    put_mem(1,   16'h11C8); // STORE R1,200
    put_mem(200, 16'h1234);
    do_reset();
    tick(3);
    check("abort_r1", 32'(dut.regfileinst.R[1]), 32'd77);
    tick(2);
    check("abort_in_exec", 32'(dbg_if.state), 32'd2);
    reset = 1'b1;
    tick(1);
    check("abort_mem200", 32'(dut.raminst.mem[200]), 32'h1234);
    check("abort_pc", 32'(dbg_if.pc), 32'd0);
    check("abort_state", 32'(dbg_if.state), 32'd0);
    reset = 1'b0;
    tick(6);
    check("restart_store", 32'(dut.raminst.mem[200]), 32'h004D);
    check("restart_pc", 32'(dbg_if.pc), 32'd2);

    // ---------------- Random memory image and register file ----------------
    for (int i = 0; i < 256; i++) put_mem(i, 16'($urandom_range(0, 65535)));
    for (int i = 0; i < 16; i++)  put_reg(i, 8'($urandom_range(0, 255)));
    do_reset();
    m_pc = 8'd0;
    for (int k = 0; k < 80; k++) begin
      model_step();
      tick(3);
      check($sformatf("rand_pc_%0d", k), 32'(dbg_if.pc), 32'(m_pc));
    end
    for (int i = 0; i < 16; i++)
      check($sformatf("rand_r%0d", i), 32'(dut.regfileinst.R[i]), 32'(m_r[i]));
    for (int i = 0; i < 256; i++)
      check($sformatf("rand_mem%0d", i), 32'(dut.raminst.mem[i]), 32'(m_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
